// File: rtl/card_pkg.sv
// Card encoding shared by the dealer/player hands and the 7-seg decoders.
package card_pkg;

   localparam int unsigned CARD_W = 4;

   typedef logic [CARD_W-1:0] card_t;

   localparam card_t CARD_NONE = 4'd0;
   localparam card_t CARD_ACE  = 4'd1;
   localparam card_t CARD_KING = 4'd13;

   // Hand fill level doubles as the FSM state.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2,
      StFull  = 2'd3
   } count_state_e;

   // Baccarat value: pips count at face value, tens and court cards count zero.
   function automatic logic [3:0] card_value(input card_t code);
      return (code <= 4'd9) ? code : 4'd0;
   endfunction

endpackage

// File: rtl/dealer_hand_card_source.sv
// Free-running card source: ascending 1..13 counter, or a re-mapped 4-bit LFSR when
// DEALER_HAND_LFSR_EN is defined.
module card_source
   import card_pkg::*;
#(
   parameter int unsigned CARD_MAX = 13
) (
   input  logic  slow_clock,
   input  logic  reset,
   output card_t gen
);

   card_t gen_q, gen_d;

`ifdef DEALER_HAND_LFSR_EN
   // x^4 + x^3 + 1, never reaches the all-zero state.
   function automatic card_t lfsr_step(input card_t s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

   always_comb begin
      gen_d = lfsr_step(gen_q);
      // Codes above the King (at most 15 then 14 in a row) are stepped over.
      for (int i = 0; i < 2; i++) begin
         if (gen_d > card_t'(CARD_MAX) || gen_d == CARD_NONE) begin
            gen_d = lfsr_step(gen_d);
         end
      end
   end
`else
   always_comb begin
      gen_d = (gen_q == card_t'(CARD_MAX)) ? CARD_ACE : gen_q + 4'd1;
   end
`endif

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         gen_q <= CARD_ACE;
      end else begin
         gen_q <= gen_d;
      end
   end

   assign gen = gen_q;

endmodule

// File: rtl/dealer_hand.sv
// Dealer hand: three card slots filled in order on deal strobes, registered
// baccarat score with one cycle of latency. Card source order set by DEALER_HAND_LFSR_EN.
module dealer_hand
   import card_pkg::*;
#(
   parameter int unsigned MAX_CARDS = 3,
   parameter int unsigned CARD_MAX  = 13
) (
   input  logic       slow_clock,
   input  logic       reset,
   input  logic       deal,
   input  logic       clear_hand,
   output logic [3:0] dealer_card1,
   output logic [3:0] dealer_card2,
   output logic [3:0] dealer_card3,
   output logic [1:0] card_count,
   output logic       hand_full,
   output logic [3:0] dealer_score,
   output logic       score_busy,
   output logic       deal_err
);

   localparam logic [1:0] FullCount = 2'(MAX_CARDS);

   card_t        gen;
   card_t        slot1_q, slot2_q, slot3_q;
   count_state_e state_q, state_d;
   logic         full_q, busy_q, err_q;
   logic [3:0]   score_q;
   logic         accept;
   logic [4:0]   raw_sum;
   logic [4:0]   mod10_sum;

   card_source #(
      .CARD_MAX(CARD_MAX)
   ) u_card_source (
      .slow_clock(slow_clock),
      .reset     (reset),
      .gen       (gen)
   );

   assign accept = deal & ~clear_hand & (state_q != StFull);

   always_comb begin
      state_d = state_q;
      if (clear_hand) begin
         state_d = StEmpty;
      end else if (accept) begin
         case (state_q)
            StEmpty: state_d = StOne;
            StOne:   state_d = StTwo;
            StTwo:   state_d = StFull;
            default: state_d = state_q;
         endcase
      end
   end

   // Sum of three values is at most 27, so two compare/subtract stages cover mod 10.
   always_comb begin
      raw_sum = {1'b0, card_value(slot1_q)} + {1'b0, card_value(slot2_q)}
              + {1'b0, card_value(slot3_q)};
      if (raw_sum >= 5'd20) begin
         mod10_sum = raw_sum - 5'd20;
      end else if (raw_sum >= 5'd10) begin
         mod10_sum = raw_sum - 5'd10;
      end else begin
         mod10_sum = raw_sum;
      end
   end

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         score_q <= 4'd0;
         slot1_q <= CARD_NONE;
         slot2_q <= CARD_NONE;
         slot3_q <= CARD_NONE;
      end else begin
         state_q <= state_d;
         full_q  <= (state_d == FullCount);
         err_q   <= deal & ~clear_hand & (state_q == StFull);
         if (clear_hand) begin
            slot1_q <= CARD_NONE;
            slot2_q <= CARD_NONE;
            slot3_q <= CARD_NONE;
            score_q <= 4'd0;
            busy_q  <= 1'b0;
         end else begin
            if (accept) begin
               case (state_q)
                  StEmpty: slot1_q <= gen;
                  StOne:   slot2_q <= gen;
                  StTwo:   slot3_q <= gen;
                  default: ;
               endcase
            end
            // Slots settled at the previous edge; fold them into the score now.
            if (busy_q) begin
               score_q <= mod10_sum[3:0];
            end
            busy_q <= accept;
         end
      end
   end

   assign dealer_card1 = slot1_q;
   assign dealer_card2 = slot2_q;
   assign dealer_card3 = slot3_q;
   assign card_count   = state_q;
   assign hand_full    = full_q;
   assign dealer_score = score_q;
   assign score_busy   = busy_q;
   assign deal_err     = err_q;

endmodule

// File: tb/tb_dealer_hand.sv
// Scoreboard bench for dealer_hand (counter build): expected score updates and
// error pulses are queued by the stimulus and checked by an independent monitor.
module tb_dealer_hand;

   logic       slow_clock = 1'b0;
   logic       reset      = 1'b0;
   logic       deal       = 1'b0;
   logic       clear_hand = 1'b0;
   logic [3:0] c1, c2, c3, score;
   logic [1:0] cnt;
   logic       full, busy, err;

   dealer_hand dut (
      .slow_clock  (slow_clock),
      .reset       (reset),
      .deal        (deal),
      .clear_hand  (clear_hand),
      .dealer_card1(c1),
      .dealer_card2(c2),
      .dealer_card3(c3),
      .card_count  (cnt),
      .hand_full   (full),
      .dealer_score(score),
      .score_busy  (busy),
      .deal_err    (err)
   );

   always #5 slow_clock = ~slow_clock;

   int n_cmp  = 0;
   int n_fail = 0;
   int edges_seen;

   // Edge index since reset release: the next edge is cycle n == edges_seen.
   always @(posedge slow_clock or posedge reset) begin
      if (reset) edges_seen <= 0;
      else       edges_seen <= edges_seen + 1;
   end

   typedef struct {
      int score;
      int c1;
      int c2;
      int c3;
      int cnt;
   } exp_t;

   exp_t score_exp[$];
   exp_t err_exp[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag, input int e1, input int e2, input int e3,
                              input int ecnt, input int escore, input int ebusy,
                              input int eerr);
      check({tag, " card1"}, c1, e1);
      check({tag, " card2"}, c2, e2);
      check({tag, " card3"}, c3, e3);
      check({tag, " count"}, cnt, ecnt);
      check({tag, " full"}, full, (ecnt == 3) ? 1 : 0);
      check({tag, " score"}, score, escore);
      check({tag, " busy"}, busy, ebusy);
      check({tag, " err"}, err, eerr);
   endtask

   // Monitor: a score update is presented when busy falls; an error when deal_err is high.
   logic prev_busy = 1'b0;
   always @(negedge slow_clock) begin : mon
      exp_t e;
      if (reset) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy && !busy) begin
            if (score_exp.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected score update: got score %0d, expected none", score);
            end else begin
               e = score_exp.pop_front();
               check("sb score", score, e.score);
               check("sb card1", c1, e.c1);
               check("sb card2", c2, e.c2);
               check("sb card3", c3, e.c3);
               check("sb count", cnt, e.cnt);
               check("sb full", full, (e.cnt == 3) ? 1 : 0);
            end
         end
         if (err) begin
            if (err_exp.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected deal_err: got 1, expected 0 (t=%0t)", $time);
            end else begin
               e = err_exp.pop_front();
               check("err card1", c1, e.c1);
               check("err card2", c2, e.c2);
               check("err card3", c3, e.c3);
               check("err count", cnt, e.cnt);
               check("err score", score, e.score);
            end
         end
         prev_busy = busy;
      end
   end

   function automatic exp_t mk(input int s, input int a, input int b, input int c, input int n);
      exp_t e;
      e.score = s; e.c1 = a; e.c2 = b; e.c3 = c; e.cnt = n;
      return e;
   endfunction

   task automatic wait_cycle(input int n);
      if (edges_seen > n) begin
         n_cmp++;
         n_fail++;
         $display("FAIL schedule: at edge %0d, required edge %0d", edges_seen, n);
      end
      while (edges_seen < n) @(negedge slow_clock);
   endtask

   // Drive deal/clear for edge n and return at the following negedge.
   task automatic strobe_at(input int n, input logic d, input logic clr, input logic accepted);
      wait_cycle(n);
      deal       = d;
      clear_hand = clr;
      @(posedge slow_clock);
      @(negedge slow_clock);
      deal       = 1'b0;
      clear_hand = 1'b0;
      if (accepted) check($sformatf("busy after deal n=%0d", n), busy, 1);
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 reset = 1'b1;
      #1 check_state("reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge slow_clock);
      @(negedge slow_clock);
      reset = 1'b0;

      // Deal sequence: cards 1, 5, 10.
      score_exp.push_back(mk(1, 1, 0, 0, 1));
      strobe_at(0, 1'b1, 1'b0, 1'b1);
      check("old score while busy", score, 0);
      score_exp.push_back(mk(6, 1, 5, 0, 2));
      strobe_at(4, 1'b1, 1'b0, 1'b1);
      score_exp.push_back(mk(6, 1, 5, 10, 3));
      strobe_at(9, 1'b1, 1'b0, 1'b1);

      // Overflow while full.
      err_exp.push_back(mk(6, 1, 5, 10, 3));
      strobe_at(11, 1'b1, 1'b0, 1'b0);
      check_state("overflow", 1, 5, 10, 3, 6, 0, 1);
      strobe_at(12, 1'b0, 1'b1, 1'b0);
      check_state("clear", 0, 0, 0, 0, 0, 0, 0);

      // Wrap 13 -> 1, then a 9 pushes the sum to 10.
      strobe_at(25, 1'b1, 1'b0, 1'b1);
      score_exp.push_back(mk(1, 13, 1, 0, 2));
      strobe_at(26, 1'b1, 1'b0, 1'b1);
      score_exp.push_back(mk(0, 13, 1, 9, 3));
      strobe_at(34, 1'b1, 1'b0, 1'b1);

      // Clear wins over a simultaneous deal on a 2-card hand.
      strobe_at(36, 1'b0, 1'b1, 1'b0);
      strobe_at(38, 1'b1, 1'b0, 1'b1);
      score_exp.push_back(mk(1, 13, 1, 0, 2));
      strobe_at(39, 1'b1, 1'b0, 1'b1);
      strobe_at(41, 1'b1, 1'b1, 1'b0);
      check_state("clear+deal", 0, 0, 0, 0, 0, 0, 0);
      score_exp.push_back(mk(4, 4, 0, 0, 1));
      strobe_at(42, 1'b1, 1'b0, 1'b1);

      // Back-to-back deals 3, 4, 5.
      strobe_at(44, 1'b0, 1'b1, 1'b0);
      score_exp.push_back(mk(2, 3, 4, 5, 3));
      strobe_at(54, 1'b1, 1'b0, 1'b1);
      strobe_at(55, 1'b1, 1'b0, 1'b1);
      strobe_at(56, 1'b1, 1'b0, 1'b1);
      wait_cycle(58);
      check("busy drop after burst", busy, 0);

      // Asynchronous reset mid-run with two cards loaded.
      strobe_at(59, 1'b0, 1'b1, 1'b0);
      strobe_at(60, 1'b1, 1'b0, 1'b1);
      score_exp.push_back(mk(9, 9, 10, 0, 2));
      strobe_at(61, 1'b1, 1'b0, 1'b1);
      wait_cycle(64);
      check("pre-reset count", cnt, 2);
      reset = 1'b1;
      #1 check_state("async reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge slow_clock);
      reset = 1'b0;
      score_exp.push_back(mk(1, 1, 0, 0, 1));
      strobe_at(0, 1'b1, 1'b0, 1'b1);
      wait_cycle(4);

      check("score queue drained", score_exp.size(), 0);
      check("err queue drained", err_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
